// File: rtl/i_cache_sa2_if.sv
// ---------------------------------------------------------------------------
// i_cache_sa2_if
// Bundles the fetch-side request/response signals and the refill bus signals
// of the i_cache_sa2 instruction cache.
//   slave  : the cache itself (takes fetch requests, issues bus beat requests)
//   master : the environment (IF stage + AXI bridge, or a testbench)
// Signals:
//   inst_addr      fetch address, bits[1:0]=0
//   inst_ena       fetch request
//   fence_i        1-cycle pulse, invalidate every line
//   inst_data      32-bit instruction, valid while inst_valid=1
//   inst_valid     1-cycle response strobe
//   cache_busy     cache not idle or fence pending
//   cache_read_ena beat request to bus
//   cache_addr     beat address (low 32 bits, 8-byte aligned)
//   cache_or_data  64-bit beat data
//   cache_in_ok    beat done, data valid this cycle
// ---------------------------------------------------------------------------
interface i_cache_sa2_if #(
    parameter int ADDR_W = 64
) ();
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ena;
    logic              fence_i;
    logic [31:0]       inst_data;
    logic              inst_valid;
    logic              cache_busy;
    logic              cache_read_ena;
    logic [31:0]       cache_addr;
    logic [63:0]       cache_or_data;
    logic              cache_in_ok;

    modport slave (
        input  inst_addr, inst_ena, fence_i, cache_or_data, cache_in_ok,
        output inst_data, inst_valid, cache_busy, cache_read_ena, cache_addr
    );

    modport master (
        output inst_addr, inst_ena, fence_i, cache_or_data, cache_in_ok,
        input  inst_data, inst_valid, cache_busy, cache_read_ena, cache_addr
    );
endinterface

// File: rtl/i_cache_sa2.sv
// ---------------------------------------------------------------------------
// i_cache_sa2
// 2-way set-associative instruction cache with LRU replacement. Misses refill
// a whole line as ascending 64-bit beats; fence_i invalidates every line.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        i_cache_sa2_if.slave (fetch request/response + refill bus)
//   perf_hit   (ICACHE_PERF_CNT_EN only) saturating count of lookup hits
//   perf_miss  (ICACHE_PERF_CNT_EN only) saturating count of lookup misses
// Build option: define ICACHE_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module i_cache_sa2 #(
    parameter int NSETS      = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    i_cache_sa2_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [63:0]  perf_hit,
    output logic [63:0]  perf_miss
`endif
);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W  = $clog2(LINE_WORDS) + 3;
    localparam int IDX_W  = $clog2(NSETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [TAG_W-1:0]  r_tag   [2][NSETS];
    logic [63:0]       r_data  [2][NSETS][LINE_WORDS];
    logic [NSETS-1:0]  r_valid [2];
    logic [NSETS-1:0]  r_lru;          // way to evict next, per set
    logic              r_way;          // hit way in RESP, victim way in REFILL
    logic [BEAT_W-1:0] r_beat;
    logic              r_gap;          // one idle cycle after each accepted beat
    logic              r_fence_pend;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_word_full;
    logic [BEAT_W-1:0] w_word;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hit_way;
    logic              w_victim;
    logic              w_last;
    logic              w_accept;
    logic              w_fence_now;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [63:0]       w_rd_beat;

    assign w_tag       = r_addr[ADDR_W-1:IDX_W+OFF_W];
    assign w_idx       = r_addr[IDX_W+OFF_W-1:OFF_W];
    // Shift/mask form keeps LINE_WORDS=1 legal (no word field at all).
    assign w_word_full = (r_addr >> 3) & ADDR_W'(LINE_WORDS - 1);
    assign w_word      = w_word_full[BEAT_W-1:0];
    assign w_hit0      = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1      = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit       = w_hit0 || w_hit1;
    assign w_hit_way   = !w_hit0;      // way0 wins if both ever match
    assign w_victim    = !r_valid[0][w_idx] ? 1'b0 :
                         !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_last      = (r_beat == BEAT_W'(LINE_WORDS - 1));
    assign w_accept    = (r_state == S_REFILL) && !r_gap && bus.cache_in_ok;
    assign w_fence_now = bus.fence_i || r_fence_pend;
    assign w_beat_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} |
                         (ADDR_W'(r_beat) << 3);
    assign w_rd_beat   = r_data[r_way][w_idx][w_word];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; a fence in IDLE swallows the same-cycle request
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.inst_ena && !bus.fence_i) w_next = S_LOOKUP;
            S_LOOKUP: w_next = w_hit ? S_RESP : S_REFILL;
            S_REFILL: if (w_accept && w_last) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.inst_valid     = 1'b0;
        bus.inst_data      = '0;
        bus.cache_read_ena = 1'b0;
        bus.cache_addr     = '0;
        bus.cache_busy     = (r_state != S_IDLE) || r_fence_pend;
        case (r_state)
            S_REFILL: begin
                bus.cache_read_ena = !r_gap;
                bus.cache_addr     = w_beat_addr[31:0];
            end
            S_RESP: begin
                bus.inst_valid = 1'b1;
                bus.inst_data  = r_addr[2] ? w_rd_beat[63:32] : w_rd_beat[31:0];
            end
            default: ;
        endcase
    end

    // Control state: valid/LRU/beat tracking. A deferred fence is applied on
    // the RESP->IDLE edge so the in-flight access still sees its line, and
    // valid is only set after the last beat so a partial line can never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_lru        <= '0;
            r_way        <= 1'b0;
            r_beat       <= '0;
            r_gap        <= 1'b0;
            r_fence_pend <= 1'b0;
        end else begin
            r_gap <= 1'b0;
            if (r_state == S_RESP)
                r_fence_pend <= 1'b0;
            else if (r_state != S_IDLE && bus.fence_i)
                r_fence_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.fence_i) begin
                        r_valid[0] <= '0;
                        r_valid[1] <= '0;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                        r_way        <= w_hit_way;
                    end else begin
                        r_way  <= w_victim;
                        r_beat <= '0;
                    end
                end
                S_REFILL: begin
                    if (w_accept) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (w_last) begin
                            r_valid[r_way][w_idx] <= 1'b1;
                            r_lru[w_idx]          <= ~r_way;
                        end else begin
                            r_gap <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (w_fence_now) begin
                        r_valid[0] <= '0;
                        r_valid[1] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data path: latched address, line data and tags (gated by valid bits)
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.inst_ena)
            r_addr <= bus.inst_addr;
        if (w_accept) begin
            r_data[r_way][w_idx][r_beat] <= bus.cache_or_data;
            if (w_last)
                r_tag[r_way][w_idx] <= w_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating hit/miss counters, one event per LOOKUP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit && perf_hit != '1)
                perf_hit <= perf_hit + 64'd1;
            if (!w_hit && perf_miss != '1)
                perf_miss <= perf_miss + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_i_cache_sa2.sv
// ---------------------------------------------------------------------------
// tb_i_cache_sa2
// Directed bench for i_cache_sa2 (NSETS=64, LINE_WORDS=4, ADDR_W=64).
// Beat data returned by the bus responder is a fixed function of the beat
// address; the expected instructions in the vector table are hand-computed
// from that function.
// ---------------------------------------------------------------------------
module tb_i_cache_sa2;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i_cache_sa2_if #(.ADDR_W(64)) bif ();

`ifdef ICACHE_PERF_CNT_EN
    logic [63:0] perf_hit;
    logic [63:0] perf_miss;
`endif

    i_cache_sa2 #(.NSETS(64), .LINE_WORDS(LW), .ADDR_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit  (perf_hit),
        .perf_miss (perf_miss)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] addr;
        bit          fence_before;  // fence_i + inst_ena together in IDLE first
        int          fence_cyc;     // cycle of fetch at which to pulse fence_i, -1 none
        bit          exp_miss;
        logic [31:0] exp_data;
    } vec_t;

    // lo half = ba[31:0] ^ 13579BDF ; hi half = ba[31:0] ^ ba[63:32] ^ CAFE0000
    function automatic logic [63:0] mem_beat(input logic [63:0] ba);
        return {ba[31:0] ^ ba[63:32] ^ 32'hCAFE_0000, ba[31:0] ^ 32'h1357_9BDF};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fetch(input logic [63:0] a, input bit exp_miss, input int fence_cyc,
                         input logic [31:0] exp_data, input string nm);
        logic [63:0] base;
        int          beats;
        int          cyc;
        int          gap_err;
        int          addr_err;
        bit          got;
        bit          prev_ok;
        logic [31:0] dat;
        base     = a & ~64'(LW * 8 - 1);
        beats    = 0;
        gap_err  = 0;
        addr_err = 0;
        got      = 1'b0;
        prev_ok  = 1'b0;
        dat      = '0;
        bif.inst_addr = a;
        bif.inst_ena  = 1'b1;
        @(posedge clk); #1;
        bif.inst_ena  = 1'b0;
        bif.inst_addr = '0;
        cyc = 1;
        while (cyc < 60) begin
            bif.fence_i = (cyc == fence_cyc);
            if (bif.inst_valid) begin
                got = 1'b1;
                dat = bif.inst_data;
                break;
            end
            if (prev_ok && bif.cache_read_ena) gap_err++;
            if (bif.cache_read_ena && !prev_ok) begin
                if (bif.cache_addr != 32'(base + 64'(beats * 8))) addr_err++;
                bif.cache_in_ok   = 1'b1;
                bif.cache_or_data = mem_beat(base + 64'(beats * 8));
                beats++;
                prev_ok = 1'b1;
            end else begin
                bif.cache_in_ok = 1'b0;
                prev_ok = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bif.fence_i     = 1'b0;
        bif.cache_in_ok = 1'b0;
        chk({nm, " valid_seen"}, 64'(got), 64'd1);
        chk({nm, " data"}, 64'(dat), 64'(exp_data));
        chk({nm, " beats"}, 64'(beats), exp_miss ? 64'(LW) : 64'd0);
        chk({nm, " beat_addr_errs"}, 64'(addr_err), 64'd0);
        chk({nm, " gap_errs"}, 64'(gap_err), 64'd0);
        if (!exp_miss) chk({nm, " hit_latency"}, 64'(cyc), 64'd2);
        @(posedge clk); #1;
        chk({nm, " strobe_drop"}, 64'(bif.inst_valid), 64'd0);
        chk({nm, " idle_busy"}, 64'(bif.cache_busy), 64'd0);
    endtask

    vec_t vecs[18];

    initial begin
        int beats;
        bit prev_ok;
        vecs[0]  = '{64'h0000_0000_8000_0004, 0, -1, 1, 32'h4AFE_0000}; // T1 cold miss
        vecs[1]  = '{64'h0000_0000_8000_0008, 0, -1, 0, 32'h9357_9BD7}; // T2 hit
        vecs[2]  = '{64'h0000_0000_8000_001C, 0, -1, 0, 32'h4AFE_0018};
        vecs[3]  = '{64'h0000_0000_8000_0800, 0, -1, 1, 32'h9357_93DF}; // B -> way1
        vecs[4]  = '{64'h0000_0000_8000_0000, 0, -1, 0, 32'h9357_9BDF}; // touch A
        vecs[5]  = '{64'h0000_0000_8000_1000, 0, -1, 1, 32'h9357_8BDF}; // C evicts B
        vecs[6]  = '{64'h0000_0000_8000_0004, 0, -1, 0, 32'h4AFE_0000}; // A hits
        vecs[7]  = '{64'h0000_0000_8000_0804, 0, -1, 1, 32'h4AFE_0800}; // B misses
        vecs[8]  = '{64'h0000_0000_8000_1004, 0, -1, 1, 32'h4AFE_1000}; // C evicts A
        vecs[9]  = '{64'h0000_0000_8000_0808, 0, -1, 0, 32'h9357_93D7}; // B hits
        vecs[10] = '{64'h0000_0000_8000_0000, 1, -1, 1, 32'h9357_9BDF}; // T4 fence in IDLE
        vecs[11] = '{64'h0000_0000_8000_0014, 0, -1, 0, 32'h4AFE_0010};
        vecs[12] = '{64'h0000_0000_8000_0020, 0,  3, 1, 32'h9357_9BFF}; // fence mid-refill
        vecs[13] = '{64'h0000_0000_8000_0020, 0, -1, 1, 32'h9357_9BFF};
        vecs[14] = '{64'h0000_0000_8000_0000, 0, -1, 1, 32'h9357_9BDF};
        vecs[15] = '{64'h0000_0001_0000_0044, 0, -1, 1, 32'hCAFE_0041}; // upper tag bits
        vecs[16] = '{64'h0000_0000_0000_0044, 0, -1, 1, 32'hCAFE_0040};
        vecs[17] = '{64'h0000_0001_0000_0044, 0, -1, 0, 32'hCAFE_0041};

        bif.inst_addr     = '0;
        bif.inst_ena      = 1'b0;
        bif.fence_i       = 1'b0;
        bif.cache_or_data = '0;
        bif.cache_in_ok   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst inst_valid", 64'(bif.inst_valid), 64'd0);
        chk("rst inst_data", 64'(bif.inst_data), 64'd0);
        chk("rst read_ena", 64'(bif.cache_read_ena), 64'd0);
        chk("rst cache_addr", 64'(bif.cache_addr), 64'd0);
        chk("rst busy", 64'(bif.cache_busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].fence_before) begin
                bif.fence_i   = 1'b1;
                bif.inst_ena  = 1'b1;
                bif.inst_addr = vecs[i].addr;
                @(posedge clk); #1;
                bif.fence_i  = 1'b0;
                bif.inst_ena = 1'b0;
                chk($sformatf("v%0d fence_drops_req", i), 64'(bif.cache_busy), 64'd0);
            end
            fetch(vecs[i].addr, vecs[i].exp_miss, vecs[i].fence_cyc, vecs[i].exp_data,
                  $sformatf("v%0d", i));
`ifdef ICACHE_PERF_CNT_EN
            if (i == 1) begin
                chk("perf_hit after T1+T2", perf_hit, 64'd1);
                chk("perf_miss after T1+T2", perf_miss, 64'd1);
            end
`endif
        end

        // cache_in_ok outside REFILL must not disturb a resident line
        bif.cache_in_ok   = 1'b1;
        bif.cache_or_data = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        bif.cache_in_ok = 1'b0;
        chk("stray in_ok busy", 64'(bif.cache_busy), 64'd0);
        fetch(64'h0000_0001_0000_0044, 1'b0, -1, 32'hCAFE_0041, "stray_in_ok hit");

        // T5: reset after two accepted beats of a refill
        bif.inst_addr = 64'h0000_0000_8000_0060;
        bif.inst_ena  = 1'b1;
        @(posedge clk); #1;
        bif.inst_ena = 1'b0;
        beats   = 0;
        prev_ok = 1'b0;
        for (int c = 0; c < 40 && beats < 2; c++) begin
            if (bif.cache_read_ena && !prev_ok) begin
                bif.cache_in_ok   = 1'b1;
                bif.cache_or_data = mem_beat(64'h8000_0060 + 64'(beats * 8));
                beats++;
                prev_ok = 1'b1;
            end else begin
                bif.cache_in_ok = 1'b0;
                prev_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        bif.cache_in_ok = 1'b0;
        chk("T5 beats before reset", 64'(beats), 64'd2);
        chk("T5 refilling before reset", 64'(bif.cache_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("T5 inst_valid", 64'(bif.inst_valid), 64'd0);
        chk("T5 inst_data", 64'(bif.inst_data), 64'd0);
        chk("T5 read_ena", 64'(bif.cache_read_ena), 64'd0);
        chk("T5 cache_addr", 64'(bif.cache_addr), 64'd0);
        chk("T5 busy", 64'(bif.cache_busy), 64'd0);
`ifdef ICACHE_PERF_CNT_EN
        chk("T5 perf_hit", perf_hit, 64'd0);
        chk("T5 perf_miss", perf_miss, 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fetch(64'h0000_0000_8000_0060, 1'b1, -1, 32'h9357_9BBF, "T5 refetch");
        fetch(64'h0000_0000_8000_0004, 1'b1, -1, 32'h4AFE_0000, "T5 A invalid");
        fetch(64'h0000_0000_8000_0064, 1'b0, -1, 32'h4AFE_0060, "T5 refilled hit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
